// File: rtl/cpu_run_ctrl_if.sv
// Key / debug-bus bundle between the board, the CPU and the run controller.
// The master side is the board and CPU; the slave side is cpu_run_ctrl.
interface cpu_run_ctrl_if;
    logic [2:0]  key;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        cpu_en;
    logic [1:0]  state;
    logic [1:0]  halt_cause;
    logic [15:0] instr_cnt;

    modport master (
        output key, bp_en, bp_addr, pc, ir,
        input  cpu_en, state, halt_cause, instr_cnt
    );

    modport slave (
        input  key, bp_en, bp_addr, pc, ir,
        output cpu_en, state, halt_cause, instr_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Execution controller: debounces the step/run/clear keys, issues single
// cpu_en pulses (step or paced free-run), stops on breakpoint or HALT opcode,
// and counts executed instructions with saturation.
module cpu_run_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         RUN_DIV         = 5000000,
    parameter logic [3:0] HALT_OP         = 4'hF
) (
    input logic          clk,
    input logic          rst,
    cpu_run_ctrl_if.slave bus
);

    localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_BP   = 2'b01;
    localparam logic [1:0] CAUSE_OP   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    // Saturating instruction counter increment.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage p0: debounce
    logic [DB_W-1:0] db_cnt_p0 [3];
    logic [2:0]      db_lvl_p0;
    logic [2:0]      db_prev_p0;
    logic [2:0]      press_p0;
    logic            clr_press, run_press, step_press;

    // Stage p1: run control
    state_t           state_p1, state_nxt;
    logic [1:0]       cause_p1, cause_nxt;
    logic [DIV_W-1:0] div_p1, div_nxt;
    logic             skip_p1, skip_nxt;
    logic             cpu_en_p1, cpu_en_nxt;
    logic [15:0]      instr_cnt_p1, cnt_nxt;
    logic             tick, is_halt_op, bp_hit;

    // Each key's level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                db_cnt_p0[i] <= '0;
            end
            db_lvl_p0  <= '0;
            db_prev_p0 <= '0;
        end else begin
            db_prev_p0 <= db_lvl_p0;
            for (int i = 0; i < 3; i++) begin
                if (bus.key[i] == db_lvl_p0[i]) begin
                    db_cnt_p0[i] <= '0;
                end else if (db_cnt_p0[i] == DB_LAST) begin
                    db_lvl_p0[i] <= bus.key[i];
                    db_cnt_p0[i] <= '0;
                end else begin
                    db_cnt_p0[i] <= db_cnt_p0[i] + DB_W'(1);
                end
            end
        end
    end

    // Rising debounced level is a one-cycle press; clear beats run/stop beats step.
    assign press_p0   = db_lvl_p0 & ~db_prev_p0;
    assign clr_press  = press_p0[2];
    assign run_press  = press_p0[1] & ~press_p0[2];
    assign step_press = press_p0[0] & ~press_p0[1] & ~press_p0[2];

    assign tick       = (div_p1 == DIV_LAST);
    assign is_halt_op = ((bus.ir & 16'hF000) == {HALT_OP, 12'h000});
    assign bp_hit     = bus.bp_en && (bus.pc == bus.bp_addr);

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p1     <= ST_IDLE;
            cause_p1     <= CAUSE_NONE;
            div_p1       <= '0;
            skip_p1      <= 1'b0;
            cpu_en_p1    <= 1'b0;
            instr_cnt_p1 <= '0;
        end else begin
            state_p1     <= state_nxt;
            cause_p1     <= cause_nxt;
            div_p1       <= div_nxt;
            skip_p1      <= skip_nxt;
            cpu_en_p1    <= cpu_en_nxt;
            instr_cnt_p1 <= cnt_nxt;
        end
    end

    // Next-state, pacing divider, stop checks and pulse scheduling.
    always_comb begin
        state_nxt  = state_p1;
        cause_nxt  = cause_p1;
        div_nxt    = div_p1;
        skip_nxt   = skip_p1;
        cpu_en_nxt = 1'b0;
        cnt_nxt    = instr_cnt_p1;
        if (clr_press) begin
            state_nxt = ST_IDLE;
            cause_nxt = CAUSE_NONE;
            div_nxt   = '0;
            skip_nxt  = 1'b0;
            cnt_nxt   = '0;
        end else begin
            case (state_p1)
                ST_IDLE: begin
                    if (run_press) begin
                        state_nxt = ST_RUN;
                        div_nxt   = '0;
                        skip_nxt  = 1'b1;
                    end else if (step_press) begin
                        cpu_en_nxt = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_press) begin
                        state_nxt = ST_IDLE;
                        div_nxt   = '0;
                    end else begin
                        div_nxt = tick ? '0 : div_p1 + DIV_W'(1);
                        if (tick) begin
                            // The first tick after (re)starting executes unconditionally
                            // so a breakpoint at the current pc does not re-trigger.
                            if (skip_p1) begin
                                cpu_en_nxt = 1'b1;
                                skip_nxt   = 1'b0;
                            end else if (is_halt_op) begin
                                state_nxt = ST_HALT;
                                cause_nxt = CAUSE_OP;
                            end else if (bp_hit) begin
                                state_nxt = ST_HALT;
                                cause_nxt = CAUSE_BP;
                            end else begin
                                cpu_en_nxt = 1'b1;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    if (run_press && cause_p1 == CAUSE_BP) begin
                        state_nxt = ST_RUN;
                        div_nxt   = '0;
                        skip_nxt  = 1'b1;
                        cause_nxt = CAUSE_NONE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
        if (cpu_en_nxt) begin
            cnt_nxt = sat_inc(instr_cnt_p1);
        end
    end

    assign bus.cpu_en     = cpu_en_p1;
    assign bus.state      = state_p1;
    assign bus.halt_cause = cause_p1;
    assign bus.instr_cnt  = instr_cnt_p1;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DEBOUNCE_CYCLES=4, RUN_DIV=8.
// Each table row holds the keys/debug inputs for a number of cycles, counts
// cpu_en pulses, and then checks pulse count, state, halt cause and counter.
module tb_cpu_run_ctrl;

    typedef struct {
        string       name;
        logic [2:0]  key;
        logic        bp_en;
        logic [15:0] ir;
        logic        pc_rst;
        int          cycles;
        int          exp_pulses;
        logic [1:0]  exp_state;
        logic [1:0]  exp_cause;
        logic [15:0] exp_cnt;
    } vec_t;

    logic clk;
    logic rst;
    cpu_run_ctrl_if bus();

    int   checks;
    int   errors;
    logic prev_en;
    logic [7:0] pc_model;
    vec_t tbl [29];
    vec_t sat [6];

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .RUN_DIV(8),
        .HALT_OP(4'hF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic [2:0] k, input logic be,
                                input logic [15:0] irv, input logic pr, input int cyc,
                                input int pul, input logic [1:0] st, input logic [1:0] ca,
                                input logic [15:0] cnt);
        vec_t v;
        v.name = nm; v.key = k; v.bp_en = be; v.ir = irv; v.pc_rst = pr;
        v.cycles = cyc; v.exp_pulses = pul; v.exp_state = st; v.exp_cause = ca;
        v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        int pulses;
        int dbl;
        bus.key   = v.key;
        bus.bp_en = v.bp_en;
        bus.ir    = v.ir;
        if (v.pc_rst) pc_model = 8'h00;
        bus.pc = pc_model;
        pulses = 0;
        dbl    = 0;
        for (int c = 0; c < v.cycles; c++) begin
            @(posedge clk);
            #1;
            if (bus.cpu_en) begin
                pulses++;
                if (prev_en) dbl++;
                pc_model = pc_model + 8'd1;
                bus.pc   = pc_model;
            end
            prev_en = bus.cpu_en;
        end
        chk({v.name, ".pulses"}, 32'(pulses), 32'(v.exp_pulses));
        chk({v.name, ".double"}, 32'(dbl), 32'd0);
        chk({v.name, ".state"}, {30'd0, bus.state}, {30'd0, v.exp_state});
        chk({v.name, ".cause"}, {30'd0, bus.halt_cause}, {30'd0, v.exp_cause});
        chk({v.name, ".cnt"}, {16'd0, bus.instr_cnt}, {16'd0, v.exp_cnt});
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        prev_en  = 1'b0;
        pc_model = 8'h00;

        //        name            key  bp  ir       pcr cyc pul st     cause  cnt
        tbl[0]  = mk("glitch",      3'b001, 0, 16'h0000, 0,  2, 0, 2'b00, 2'b00, 16'd0);
        tbl[1]  = mk("glitch_rel",  3'b000, 0, 16'h0000, 0,  6, 0, 2'b00, 2'b00, 16'd0);
        tbl[2]  = mk("step_hold",   3'b001, 0, 16'h0000, 0, 10, 1, 2'b00, 2'b00, 16'd1);
        tbl[3]  = mk("step_rel",    3'b000, 0, 16'h0000, 0,  6, 0, 2'b00, 2'b00, 16'd1);
        tbl[4]  = mk("run_press",   3'b010, 0, 16'h0000, 0,  6, 0, 2'b10, 2'b00, 16'd1);
        tbl[5]  = mk("run_rel",     3'b000, 0, 16'h0000, 0,  6, 0, 2'b10, 2'b00, 16'd1);
        tbl[6]  = mk("run_go",      3'b000, 0, 16'h0000, 0, 40, 5, 2'b10, 2'b00, 16'd6);
        tbl[7]  = mk("stop_press",  3'b010, 0, 16'h0000, 0,  6, 1, 2'b00, 2'b00, 16'd7);
        tbl[8]  = mk("stop_rel",    3'b000, 0, 16'h0000, 0, 20, 0, 2'b00, 2'b00, 16'd7);
        tbl[9]  = mk("clear",       3'b100, 0, 16'h0000, 1,  6, 0, 2'b00, 2'b00, 16'd0);
        tbl[10] = mk("clear_rel",   3'b000, 0, 16'h0000, 0,  6, 0, 2'b00, 2'b00, 16'd0);
        tbl[11] = mk("bp_press",    3'b010, 1, 16'h0000, 0,  6, 0, 2'b10, 2'b00, 16'd0);
        tbl[12] = mk("bp_rel",      3'b000, 1, 16'h0000, 0,  6, 0, 2'b10, 2'b00, 16'd0);
        tbl[13] = mk("bp_go",       3'b000, 1, 16'h0000, 0, 41, 5, 2'b11, 2'b01, 16'd5);
        tbl[14] = mk("bp_wait",     3'b000, 1, 16'h0000, 0, 10, 0, 2'b11, 2'b01, 16'd5);
        tbl[15] = mk("resume",      3'b010, 1, 16'h0000, 0,  6, 0, 2'b10, 2'b00, 16'd5);
        tbl[16] = mk("resume_rel",  3'b000, 1, 16'h0000, 0,  6, 0, 2'b10, 2'b00, 16'd5);
        tbl[17] = mk("resume_go",   3'b000, 1, 16'h0000, 0,  9, 2, 2'b10, 2'b00, 16'd7);
        tbl[18] = mk("halt_op",     3'b000, 1, 16'hF000, 0,  8, 0, 2'b11, 2'b10, 16'd7);
        tbl[19] = mk("hop_run",     3'b010, 1, 16'hF000, 0,  6, 0, 2'b11, 2'b10, 16'd7);
        tbl[20] = mk("hop_run_rel", 3'b000, 1, 16'hF000, 0,  6, 0, 2'b11, 2'b10, 16'd7);
        tbl[21] = mk("hop_step",    3'b001, 1, 16'hF000, 0,  6, 0, 2'b11, 2'b10, 16'd7);
        tbl[22] = mk("hop_step_rel",3'b000, 1, 16'hF000, 0,  6, 0, 2'b11, 2'b10, 16'd7);
        tbl[23] = mk("hop_clear",   3'b100, 1, 16'hF000, 0,  6, 0, 2'b00, 2'b00, 16'd0);
        tbl[24] = mk("hop_clr_rel", 3'b000, 1, 16'h0000, 0,  6, 0, 2'b00, 2'b00, 16'd0);
        tbl[25] = mk("all_keys",    3'b111, 0, 16'h0000, 0,  6, 0, 2'b00, 2'b00, 16'd0);
        tbl[26] = mk("all_keys_rel",3'b000, 0, 16'h0000, 0,  6, 0, 2'b00, 2'b00, 16'd0);
        tbl[27] = mk("run3_press",  3'b010, 0, 16'h0000, 0,  6, 0, 2'b10, 2'b00, 16'd0);
        tbl[28] = mk("run3_rel",    3'b000, 0, 16'h0000, 0,  9, 1, 2'b10, 2'b00, 16'd1);

        sat[0]  = mk("sat_step1",   3'b001, 0, 16'h0000, 0,  6, 1, 2'b00, 2'b00, 16'hFFFE);
        sat[1]  = mk("sat_rel1",    3'b000, 0, 16'h0000, 0,  6, 0, 2'b00, 2'b00, 16'hFFFE);
        sat[2]  = mk("sat_step2",   3'b001, 0, 16'h0000, 0,  6, 1, 2'b00, 2'b00, 16'hFFFF);
        sat[3]  = mk("sat_rel2",    3'b000, 0, 16'h0000, 0,  6, 0, 2'b00, 2'b00, 16'hFFFF);
        sat[4]  = mk("sat_step3",   3'b001, 0, 16'h0000, 0,  6, 1, 2'b00, 2'b00, 16'hFFFF);
        sat[5]  = mk("sat_rel3",    3'b000, 0, 16'h0000, 0,  6, 0, 2'b00, 2'b00, 16'hFFFF);

        rst         = 1'b0;
        bus.key     = 3'b000;
        bus.bp_en   = 1'b0;
        bus.bp_addr = 8'h05;
        bus.pc      = 8'h00;
        bus.ir      = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.state", {30'd0, bus.state}, 32'd0);
        chk("reset.cause", {30'd0, bus.halt_cause}, 32'd0);
        chk("reset.cnt", {16'd0, bus.instr_cnt}, 32'd0);
        chk("reset.cpu_en", {31'd0, bus.cpu_en}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 29; i++) begin
            apply(tbl[i]);
        end

        // Asynchronous reset in the middle of RUN, between ticks.
        #2;
        rst = 1'b0;
        #1;
        chk("arst.state", {30'd0, bus.state}, 32'd0);
        chk("arst.cause", {30'd0, bus.halt_cause}, 32'd0);
        chk("arst.cnt", {16'd0, bus.instr_cnt}, 32'd0);
        chk("arst.cpu_en", {31'd0, bus.cpu_en}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        prev_en = 1'b0;
        apply(mk("post_rst", 3'b000, 0, 16'h0000, 0, 30, 0, 2'b00, 2'b00, 16'd0));

        // Counter saturation, starting from a preloaded value near the top.
        force dut.instr_cnt_p1 = 16'hFFFD;
        #1;
        release dut.instr_cnt_p1;
        for (int i = 0; i < 6; i++) begin
            apply(sat[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
